fir_tap_accum: RTL

Downstream stage of the per-tap product unit: consumes the signed 34-bit tap products and accumulates `NUM_TAPS` consecutive products into one FIR output sample. Each completed sum is rounded, scaled, and range-reduced to `OUT_WIDTH`, then buffered in a 2-entry output queue. The queue drains through a valid/ready handshake. The upstream has no backpressure, so overflow of the queue is flagged rather than stalled.

---
 rtl/fir_pkg.sv | 44 ++++
 rtl/fir_tap_accum_if.sv | 25 ++
 rtl/fir_out_fifo.sv | 77 +++++++
 rtl/fir_tap_accum.sv | 88 ++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap accumulator: widths and the round/range-reduce helper.
// Build option: define FIR_ACC_SAT_EN to clamp out-of-range samples instead of wrapping.
package fir_pkg;

    localparam int unsigned FIR_SUM_WIDTH = 34;
    // Working width for the rounding helper; must exceed the accumulator width by at least one bit.
    localparam int unsigned FIR_MAX_W     = 64;

    function automatic int unsigned fir_acc_width(input int unsigned sum_w,
                                                  input int unsigned num_taps);
        return sum_w + 32'($clog2(num_taps));
    endfunction

    // Round half toward +inf, arithmetic shift, then reduce to out_w bits (sign-extended result).
    function automatic logic signed [FIR_MAX_W-1:0] fir_round_sat(
        input logic signed [FIR_MAX_W-1:0] total,
        input int unsigned                 shift,
        input int unsigned                 out_w
    );
        logic signed [FIR_MAX_W-1:0] r;
        logic signed [FIR_MAX_W-1:0] half;
`ifdef FIR_ACC_SAT_EN
        logic signed [FIR_MAX_W-1:0] lim;
`endif
        r    = total;
        half = '0;
        if (shift != 0) begin
            half = FIR_MAX_W'(1) << (shift - 1);
            r    = (total + half) >>> shift;
        end
`ifdef FIR_ACC_SAT_EN
        lim = FIR_MAX_W'(1) << (out_w - 1);
        if (r > lim - 1) begin
            r = lim - 1;
        end else if (r < -lim) begin
            r = -lim;
        end
`else
        r = (r <<< (FIR_MAX_W - out_w)) >>> (FIR_MAX_W - out_w);
`endif
        return r;
    endfunction

endpackage

// File: rtl/fir_tap_accum_if.sv
// Product-in / sample-out bundle of the FIR tap accumulator.
interface fir_tap_accum_if #(
    parameter int unsigned SUM_WIDTH = fir_pkg::FIR_SUM_WIDTH,
    parameter int unsigned OUT_WIDTH = 24,
    parameter int unsigned CNT_WIDTH = 3
);
    logic [SUM_WIDTH-1:0] in_sum;
    logic                 in_sum_vld;
    logic                 clear;
    logic [OUT_WIDTH-1:0] out_sample;
    logic                 out_sample_vld;
    logic                 out_sample_rdy;
    logic [CNT_WIDTH-1:0] tap_cnt;
    logic                 overrun;

    modport master (
        output in_sum, in_sum_vld, clear, out_sample_rdy,
        input  out_sample, out_sample_vld, tap_cnt, overrun
    );

    modport slave (
        input  in_sum, in_sum_vld, clear, out_sample_rdy,
        output out_sample, out_sample_vld, tap_cnt, overrun
    );
endinterface

// File: rtl/fir_out_fifo.sv
// Two-entry output queue with a registered head; push and pop in one cycle are both honoured.
module fir_out_fifo #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned DEPTH = 2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        head_d  = (count_d != 2'd0) ? mem_d[rd_ptr_d] : '0;
        empty_d = (count_d == 2'd0);
        full_d  = (count_d == 2'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign data_o  = head_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/fir_tap_accum.sv
// Accumulates NUM_TAPS tap products per output sample, rounds/scales/range-reduces, and queues it.
// Build option: define FIR_ACC_SAT_EN to saturate instead of wrap on range reduction.
module fir_tap_accum
    import fir_pkg::*;
#(
    parameter int unsigned SUM_WIDTH = FIR_SUM_WIDTH,
    parameter int unsigned NUM_TAPS  = 8,
    parameter int unsigned SHIFT     = 4,
    parameter int unsigned OUT_WIDTH = 24
) (
    input  logic          clk,
    input  logic          reset,
    fir_tap_accum_if.slave bus
);
    localparam int unsigned ACC_W = fir_acc_width(SUM_WIDTH, NUM_TAPS);
    localparam int unsigned CNT_W = $clog2(NUM_TAPS);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] total;
    logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
    logic                    overrun_q, overrun_d;
    logic                    last_tap;
    logic                    push;
    logic                    pop;
    logic [OUT_WIDTH-1:0]    sample;
    logic [OUT_WIDTH-1:0]    fifo_data;
    logic                    fifo_empty;
    logic                    fifo_full;

    assign in_ext   = ACC_W'($signed(bus.in_sum));
    assign total    = acc_q + in_ext;
    assign last_tap = (tap_cnt_q == CNT_W'(NUM_TAPS - 1));
    assign sample   = OUT_WIDTH'(fir_round_sat(FIR_MAX_W'(total), SHIFT, OUT_WIDTH));
    assign pop      = bus.out_sample_rdy && !fifo_empty;

    // Clear outranks a coincident product; the last product of a block is pushed, not stored.
    always_comb begin
        acc_d     = acc_q;
        tap_cnt_d = tap_cnt_q;
        push      = 1'b0;
        if (bus.clear) begin
            acc_d     = '0;
            tap_cnt_d = '0;
        end else if (bus.in_sum_vld) begin
            if (last_tap) begin
                acc_d     = '0;
                tap_cnt_d = '0;
                push      = 1'b1;
            end else begin
                acc_d     = total;
                tap_cnt_d = tap_cnt_q + CNT_W'(1);
            end
        end
        overrun_d = overrun_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            tap_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            tap_cnt_q <= tap_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    fir_out_fifo #(
        .WIDTH (OUT_WIDTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .data_i  (sample),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.out_sample     = fifo_data;
    assign bus.out_sample_vld = !fifo_empty;
    assign bus.tap_cnt        = tap_cnt_q;
    assign bus.overrun        = overrun_q;

endmodule
